// File: rtl/pwm_mc_pkg.sv
// Shared widths, default geometry and helpers for the multi-channel dithered PWM generator.
package pwm_mc_pkg;
    localparam int PWM_NCH = 4;
    localparam int PWM_VW  = 8;
    localparam int PWM_DW  = 4;
    localparam int PWM_CW  = PWM_VW + PWM_DW;

    typedef struct packed {
        logic [PWM_VW-1:0] coarse;
        logic [PWM_DW-1:0] fine;
    } chan_cfg_t;

    // Spreads the channel period counters evenly across one period when staggering is enabled.
    function automatic int stagger_off(input int idx, input int full, input int nch, input int stagger);
        return (stagger != 0) ? (idx * (full + 1)) / nch : 0;
    endfunction
endpackage

// File: rtl/pwm_mc_chan.sv
// One PWM channel: shadow config, first-order dither accumulator, duty register and output compare.
module pwm_mc_chan
    import pwm_mc_pkg::*;
#(
    parameter int VW   = PWM_VW,
    parameter int DW   = PWM_DW,
    parameter int FULL = 2**VW - 1,
    parameter int OFF  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VW-1:0]    cnt,
    input  logic             load,
    input  logic [VW+DW-1:0] cfg,
    input  logic             en,
    output logic             pwm
);
    localparam logic [VW:0] FULL_W = (VW+1)'(FULL);
    localparam logic [VW:0] PER_W  = (VW+1)'(FULL + 1);
    localparam logic [VW:0] OFF_W  = (VW+1)'(OFF);

    logic [VW-1:0] coarse_sh;
    logic [VW-1:0] eff_coarse;
    logic [DW-1:0] fine_sh;
    logic [DW-1:0] eff_fine;
    logic [DW-1:0] acc;
    logic [DW-1:0] eff_acc;
    logic          en_sh;
    logic [VW:0]   duty;
    logic [VW:0]   c_sum;
    logic [VW:0]   c_pos;
    logic [VW:0]   coarse_cl;
    logic [VW:0]   duty_sum;
    logic [VW:0]   duty_nxt;
    logic [DW:0]   acc_sum;
    logic          wrap;

    // A capture on this channel's own wrap must already dither from the new values with a cleared accumulator.
    always_comb begin
        c_sum      = {1'b0, cnt} + OFF_W;
        c_pos      = (c_sum > FULL_W) ? c_sum - PER_W : c_sum;
        wrap       = (c_pos == FULL_W);
        eff_coarse = load ? cfg[VW+DW-1:DW] : coarse_sh;
        eff_fine   = load ? cfg[DW-1:0] : fine_sh;
        eff_acc    = load ? '0 : acc;
        acc_sum    = {1'b0, eff_acc} + {1'b0, eff_fine};
        coarse_cl  = ({1'b0, eff_coarse} > FULL_W) ? PER_W : {1'b0, eff_coarse};
        duty_sum   = coarse_cl + {{VW{1'b0}}, acc_sum[DW]};
        duty_nxt   = (duty_sum > PER_W) ? PER_W : duty_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coarse_sh <= '0;
            fine_sh   <= '0;
            en_sh     <= 1'b0;
            acc       <= '0;
            duty      <= '0;
            pwm       <= 1'b0;
        end else begin
            if (load) begin
                coarse_sh <= cfg[VW+DW-1:DW];
                fine_sh   <= cfg[DW-1:0];
                en_sh     <= en;
            end
            if (wrap) begin
                acc  <= acc_sum[DW-1:0];
                duty <= duty_nxt;
            end else if (load) begin
                acc <= '0;
            end
            pwm <= en_sh & (c_pos < duty);
        end
    end
endmodule

// File: rtl/red_pitaya_pwm_mc.sv
// Multi-channel dithered PWM generator: shared base/period counters and the metacycle-aligned
// update handshake; per-channel duty generation lives in pwm_mc_chan.
module red_pitaya_pwm_mc
    import pwm_mc_pkg::*;
#(
    parameter int NCH     = PWM_NCH,
    parameter int VW      = PWM_VW,
    parameter int DW      = PWM_DW,
    parameter int FULL    = 2**VW - 1,
    parameter int STAGGER = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*(VW+DW)-1:0] cfg,
    input  logic [NCH-1:0]         en,
    input  logic                   upd_req,
    output logic                   upd_ack,
    output logic [NCH-1:0]         pwm_o,
    output logic                   pwm_s
);
    localparam int            CW     = VW + DW;
    localparam logic [VW-1:0] FULL_V = VW'(FULL);
    localparam logic [VW-1:0] PRE_V  = VW'(FULL - 1);

    logic [VW-1:0] cnt;
    logic [DW-1:0] pcnt;
    logic          pending;
    logic          cnt_wrap;
    logic          boundary;
    logic          load;

    always_comb begin
        cnt_wrap = (cnt == FULL_V);
        boundary = cnt_wrap && (&pcnt);
        load     = boundary && (pending || upd_req);
        pwm_s    = (cnt == PRE_V) && (&pcnt);
    end

    // Requests are only remembered until the next boundary; several of them collapse into one capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            pcnt    <= '0;
            pending <= 1'b0;
            upd_ack <= 1'b0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) begin
                pcnt <= pcnt + 1'b1;
            end
            pending <= load ? 1'b0 : (pending | upd_req);
            upd_ack <= load;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pwm_mc_chan #(
            .VW   (VW),
            .DW   (DW),
            .FULL (FULL),
            .OFF  (stagger_off(i, FULL, NCH, STAGGER))
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .cnt  (cnt),
            .load (load),
            .cfg  (cfg[i*CW +: CW]),
            .en   (en[i]),
            .pwm  (pwm_o[i])
        );
    end
endmodule

// File: tb/tb_red_pitaya_pwm_mc.sv
// Bench for red_pitaya_pwm_mc: a plain and a staggered instance share stimulus and are compared
// against a time-indexed behavioural model plus per-metacycle high-count and edge-spacing expectations.
module tb_red_pitaya_pwm_mc;
    import pwm_mc_pkg::*;

    localparam int NCH  = 4;
    localparam int VW   = 8;
    localparam int DW   = 4;
    localparam int FULL = 255;
    localparam int P    = FULL + 1;
    localparam int NPER = 1 << DW;
    localparam int META = P * NPER;
    localparam int CW   = VW + DW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              upd_req;
    logic [NCH*CW-1:0] cfg;
    logic [NCH-1:0]    en;
    logic              ack_a, ack_b, sync_a, sync_b;
    logic [NCH-1:0]    pwm_a, pwm_b;
    int                n_checks = 0;
    int                n_errors = 0;

    always #5 clk = ~clk;

    red_pitaya_pwm_mc #(.NCH(NCH), .VW(VW), .DW(DW), .FULL(FULL), .STAGGER(0)) dut_a (
        .clk(clk), .rst(rst), .cfg(cfg), .en(en), .upd_req(upd_req),
        .upd_ack(ack_a), .pwm_o(pwm_a), .pwm_s(sync_a)
    );

    red_pitaya_pwm_mc #(.NCH(NCH), .VW(VW), .DW(DW), .FULL(FULL), .STAGGER(1)) dut_b (
        .clk(clk), .rst(rst), .cfg(cfg), .en(en), .upd_req(upd_req),
        .upd_ack(ack_b), .pwm_o(pwm_b), .pwm_s(sync_b)
    );

    // Reference model: m_t counts cycles since reset release, so counters are plain arithmetic on it.
    int             m_t;
    int             m_coarse[NCH];
    int             m_fine[NCH];
    logic [NCH-1:0] m_en;
    int             m_acc[2][NCH];
    int             m_duty[2][NCH];
    logic [NCH-1:0] m_pwm[2];
    logic           m_pend, m_ack;
    logic           exp_sync;
    logic [2*NCH+3:0] obs, exp_vec;

    assign exp_sync = ((m_t % META) == META - 2);
    assign obs      = {pwm_a, pwm_b, ack_a, ack_b, sync_a, sync_b};
    assign exp_vec  = {m_pwm[0], m_pwm[1], m_ack, m_ack, exp_sync, exp_sync};

    function automatic int cfg_coarse(input int ch);
        chan_cfg_t f;
        f = cfg[ch*CW +: CW];
        return int'(f.coarse);
    endfunction

    function automatic int cfg_fine(input int ch);
        chan_cfg_t f;
        f = cfg[ch*CW +: CW];
        return int'(f.fine);
    endfunction

    function automatic int pos(input int s, input int ch);
        int off;
        off = (s == 1) ? (ch * P) / NCH : 0;
        return ((m_t % P) + off) % P;
    endfunction

    function automatic bit m_load();
        return ((m_t % META) == META - 1) && (m_pend || upd_req);
    endfunction

    function automatic int eff_acc(input int s, input int ch);
        return m_load() ? 0 : m_acc[s][ch];
    endfunction

    function automatic int eff_fine(input int ch);
        return m_load() ? cfg_fine(ch) : m_fine[ch];
    endfunction

    function automatic int next_duty(input int s, input int ch);
        int c;
        c = m_load() ? cfg_coarse(ch) : m_coarse[ch];
        if (c > FULL) c = FULL + 1;
        c = c + (eff_acc(s, ch) + eff_fine(ch)) / NPER;
        return (c > FULL + 1) ? FULL + 1 : c;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t    <= 0;
            m_pend <= 1'b0;
            m_ack  <= 1'b0;
            m_en   <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                m_coarse[ch] <= 0;
                m_fine[ch]   <= 0;
            end
            for (int s = 0; s < 2; s++) begin
                m_pwm[s] <= '0;
                for (int ch = 0; ch < NCH; ch++) begin
                    m_acc[s][ch]  <= 0;
                    m_duty[s][ch] <= 0;
                end
            end
        end else begin
            m_t    <= m_t + 1;
            m_ack  <= m_load();
            m_pend <= m_load() ? 1'b0 : (m_pend | upd_req);
            if (m_load()) begin
                m_en <= en;
                for (int ch = 0; ch < NCH; ch++) begin
                    m_coarse[ch] <= cfg_coarse(ch);
                    m_fine[ch]   <= cfg_fine(ch);
                end
            end
            for (int s = 0; s < 2; s++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    m_pwm[s][ch] <= m_en[ch] && (pos(s, ch) < m_duty[s][ch]);
                    if (pos(s, ch) == FULL) begin
                        m_acc[s][ch]  <= (eff_acc(s, ch) + eff_fine(ch)) % NPER;
                        m_duty[s][ch] <= next_duty(s, ch);
                    end else if (m_load()) begin
                        m_acc[s][ch] <= 0;
                    end
                end
            end
        end
    end

    task automatic set_chan(input int ch, input int coarse, input int fine);
        chan_cfg_t f;
        f.coarse = VW'(coarse);
        f.fine   = DW'(fine);
        cfg[ch*CW +: CW] = f;
    endtask

    task automatic test_reset();
        int first_sync;
        int highs;
        first_sync = -1;
        highs = 0;
        rst = 1'b1;
        upd_req = 1'b0;
        en = '1;
        for (int ch = 0; ch < NCH; ch++) set_chan(ch, $urandom_range(0, 255), $urandom_range(0, 15));
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (obs !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs got=%h required=0", obs);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < META + 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL reset_model t=%0d got=%h required=%h", m_t, obs, exp_vec);
            end
            if (pwm_a != '0 || pwm_b != '0) highs++;
            if (sync_a === 1'b1 && first_sync < 0) first_sync = m_t;
        end
        n_checks++;
        if (highs != 0) begin
            n_errors++;
            $display("FAIL reset_idle_high got=%0d required=0", highs);
        end
        n_checks++;
        if (first_sync != META - 2) begin
            n_errors++;
            $display("FAIL first_sync got=%0d required=%0d", first_sync, META - 2);
        end
    endtask

    task automatic test_basic();
        int hi[NCH];
        int exp_hi[NCH];
        int per_hi;
        int waited;
        set_chan(0, 8'h80, 4);
        set_chan(1, 0, 0);
        set_chan(2, 255, 15);
        set_chan(3, 255, 15);
        en = 4'b0111;
        exp_hi[0] = 128 * NPER + 4;
        exp_hi[1] = 0;
        exp_hi[2] = 255 * NPER + 15;
        exp_hi[3] = 0;
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        waited = 0;
        while (ack_a !== 1'b1 && waited < META + 4) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL basic_wait_model t=%0d got=%h required=%h", m_t, obs, exp_vec);
            end
            waited++;
        end
        n_checks++;
        if (ack_a !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_ack_timeout got=%b required=1", ack_a);
            return;
        end
        n_checks++;
        if ((m_t % META) != 0) begin
            n_errors++;
            $display("FAIL basic_ack_phase got=%0d required=0", m_t % META);
        end
        for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
        per_hi = 0;
        for (int k = 0; k < META; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL basic_model t=%0d got=%h required=%h", m_t, obs, exp_vec);
            end
            for (int ch = 0; ch < NCH; ch++) if (pwm_a[ch]) hi[ch]++;
            if (pwm_a[0]) per_hi++;
            if (k % P == P - 1) begin
                n_checks++;
                if (per_hi != 128 && per_hi != 129) begin
                    n_errors++;
                    $display("FAIL basic_period_high got=%0d required=128or129", per_hi);
                end
                per_hi = 0;
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            n_checks++;
            if (hi[ch] != exp_hi[ch]) begin
                n_errors++;
                $display("FAIL basic_meta_high ch=%0d got=%0d required=%0d", ch, hi[ch], exp_hi[ch]);
            end
        end
    endtask

    task automatic test_stagger();
        int rises[NCH];
        int rise_t[NCH];
        int waited;
        int exp_d;
        logic [NCH-1:0] prev;
        for (int ch = 0; ch < NCH; ch++) set_chan(ch, 64, 0);
        en = '1;
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        waited = 0;
        while (ack_a !== 1'b1 && waited < META + 4) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (ack_a !== 1'b1) begin
            n_errors++;
            $display("FAIL stagger_ack_timeout got=%b required=1", ack_a);
            return;
        end
        repeat (P) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL stagger_model t=%0d got=%h required=%h", m_t, obs, exp_vec);
            end
        end
        prev = pwm_b;
        for (int ch = 0; ch < NCH; ch++) begin
            rises[ch] = 0;
            rise_t[ch] = -1;
        end
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                if (pwm_b[ch] && !prev[ch]) begin
                    rises[ch]++;
                    rise_t[ch] = m_t;
                end
            end
            prev = pwm_b;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            n_checks++;
            if (rises[ch] != 1) begin
                n_errors++;
                $display("FAIL stagger_rises ch=%0d got=%0d required=1", ch, rises[ch]);
            end
            exp_d = (P - (ch * P) / NCH) % P;
            n_checks++;
            if ((rise_t[ch] - rise_t[0] + P) % P != exp_d) begin
                n_errors++;
                $display("FAIL stagger_spacing ch=%0d got=%0d required=%0d", ch,
                         (rise_t[ch] - rise_t[0] + P) % P, exp_d);
            end
        end
    endtask

    task automatic test_upd_timing();
        int co[NCH];
        int fi[NCH];
        int hi[NCH];
        int waited;
        int acks;
        waited = 0;
        while ((m_t % META) != META - 1 && waited < META + 4) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if ((m_t % META) != META - 1) begin
            n_errors++;
            $display("FAIL upd_align got=%0d required=%0d", m_t % META, META - 1);
            return;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            co[ch] = $urandom_range(1, 254);
            fi[ch] = $urandom_range(0, 15);
            set_chan(ch, co[ch], fi[ch]);
        end
        en = '1;
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        n_checks++;
        if (ack_a !== 1'b1 || ack_b !== 1'b1) begin
            n_errors++;
            $display("FAIL upd_boundary_ack got=%b%b required=11", ack_a, ack_b);
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
            acks = 0;
            for (int k = 0; k < META; k++) begin
                @(negedge clk);
                n_checks++;
                if (obs !== exp_vec) begin
                    n_errors++;
                    $display("FAIL upd_model t=%0d got=%h required=%h", m_t, obs, exp_vec);
                end
                for (int ch = 0; ch < NCH; ch++) if (pwm_a[ch]) hi[ch]++;
                if (ack_a) acks++;
                if (pass == 1 && k == 1000) begin
                    for (int ch = 0; ch < NCH; ch++) set_chan(ch, $urandom_range(0, 255), $urandom_range(0, 15));
                end
            end
            for (int ch = 0; ch < NCH; ch++) begin
                n_checks++;
                if (hi[ch] != NPER * co[ch] + fi[ch]) begin
                    n_errors++;
                    $display("FAIL upd_meta_high pass=%0d ch=%0d got=%0d required=%0d", pass, ch, hi[ch],
                             NPER * co[ch] + fi[ch]);
                end
            end
            n_checks++;
            if (acks != 0) begin
                n_errors++;
                $display("FAIL upd_spurious_ack pass=%0d got=%0d required=0", pass, acks);
            end
        end
    endtask

    task automatic test_back_to_back();
        int co[NCH];
        int fi[NCH];
        int hi[NCH];
        int acks;
        int waited;
        waited = 0;
        while ((m_t % META) != 0 && waited < META + 4) begin
            @(negedge clk);
            waited++;
        end
        acks = 0;
        for (int k = 0; k < META; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL b2b_model t=%0d got=%h required=%h", m_t, obs, exp_vec);
            end
            if (ack_a) acks++;
            upd_req = (k == 100 || k == 2000 || k == 3000);
            if (k == 100 || k == 2000) begin
                for (int ch = 0; ch < NCH; ch++) set_chan(ch, $urandom_range(0, 255), $urandom_range(0, 15));
            end
            if (k == 4000) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    co[ch] = $urandom_range(150, 254);
                    fi[ch] = $urandom_range(0, 15);
                    set_chan(ch, co[ch], fi[ch]);
                end
            end
        end
        upd_req = 1'b0;
        n_checks++;
        if (acks != 1) begin
            n_errors++;
            $display("FAIL b2b_ack_count got=%0d required=1", acks);
        end
        for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
        for (int k = 0; k < META; k++) begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) if (pwm_a[ch]) hi[ch]++;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            n_checks++;
            if (hi[ch] != NPER * co[ch] + fi[ch]) begin
                n_errors++;
                $display("FAIL b2b_meta_high ch=%0d got=%0d required=%0d", ch, hi[ch], NPER * co[ch] + fi[ch]);
            end
        end
    endtask

    task automatic test_reset_pending();
        int acks;
        int highs;
        int waited;
        repeat (100) @(negedge clk);
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (pwm_a !== '1) begin
            n_errors++;
            $display("FAIL rstp_pre_high got=%b required=1111", pwm_a);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL rstp_async_clear got=%h required=0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        highs = 0;
        for (int k = 0; k < META + 200; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL rstp_model t=%0d got=%h required=%h", m_t, obs, exp_vec);
            end
            if (ack_a || ack_b) acks++;
            if (pwm_a != '0 || pwm_b != '0) highs++;
        end
        n_checks++;
        if (acks != 0) begin
            n_errors++;
            $display("FAIL rstp_stale_ack got=%0d required=0", acks);
        end
        n_checks++;
        if (highs != 0) begin
            n_errors++;
            $display("FAIL rstp_idle_high got=%0d required=0", highs);
        end
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        waited = 0;
        while (ack_a !== 1'b1 && waited < META + 4) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (ack_a !== 1'b1 || (m_t % META) != 0) begin
            n_errors++;
            $display("FAIL rstp_new_ack got=%b phase=%0d required=1 phase=0", ack_a, m_t % META);
        end
    endtask

    initial begin
        rst = 1'b1;
        upd_req = 1'b0;
        cfg = '0;
        en = '0;
        test_reset();
        test_basic();
        test_stagger();
        test_upd_timing();
        test_back_to_back();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/red_pitaya_pwm_mc.md
Name: red_pitaya_pwm_mc

Overview:
Multi-channel, parametrised PWM generator with first-order dithered fine resolution, for driving RC-filtered slow analog outputs.
- Each channel's duty value is split into a coarse part (compared against a period counter) and a fine part (accumulated once per period; its carry stretches that period by one cycle).
- New settings are captured via a request/acknowledge handshake and applied atomically at the metacycle boundary, so outputs never glitch mid-period.
- Optional phase staggering spreads channel edges to reduce supply ripple.

Parameters:
NCH, 4, number of PWM channels (1..8)
VW, 8, coarse value width; the period counter is VW bits wide
DW, 4, fine (dither) width; one metacycle is 2**DW periods
FULL, 2**VW-1, last period-counter value; period = FULL+1 cycles; must satisfy 1 <= FULL <= 2**VW-1
STAGGER, 0, 1 = channel i period counter offset by (i*(FULL+1))/NCH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg  in  NCH*(VW+DW)  channel i value at bits [i*(VW+DW) +: VW+DW]; upper VW bits coarse, lower DW bits fine
en  in  NCH  per-channel enable, sampled with cfg
upd_req  in  1  request to capture cfg/en at next metacycle boundary
upd_ack  out  1  one-cycle pulse: capture performed
pwm_o  out  NCH  PWM outputs (registered)
pwm_s  out  1  metacycle sync pulse

Behaviour:
Reset
- All state clears asynchronously on rst: base counter, period counter, shadows, en shadow, accumulators, pending, pwm_o, upd_ack, pwm_s all 0.
- Reset mid-period forces outputs low immediately; any pending request is discarded.

Counters
- Base counter cnt: 0..FULL, wraps to 0.
- Period counter pcnt (DW bits): increments when cnt==FULL.
- Boundary = cycle where cnt==FULL and pcnt==2**DW-1.
- Channel counter c_i = (cnt + off_i) mod (FULL+1), where off_i = 0 if STAGGER==0. Offset arithmetic is done in VW+1 bits before the modulo.

Handshake
- upd_req sets pending (level-sampled each cycle).
- At the boundary, if pending or upd_req is high:
  - shadow_i <= cfg_i, en_sh <= en, accumulators cleared;
  - pending <= 0; upd_ack pulses 1 the next cycle.
- upd_req asserted exactly on the boundary cycle is captured in that same boundary, with cfg sampled that cycle.
- Multiple requests before one boundary produce one capture and one ack, using cfg as sampled at the boundary.
- No capture occurs outside a boundary.

Dither (per channel, at its own wrap, c_i==FULL)
- {carry, acc_i} <= acc_i + fine_i, in DW+1 bits.
- duty_i <= coarse_i + carry, in VW+1 bits, range 0..FULL+1.

Output
- pwm_o[i] <= en_sh[i] & (c_i < duty_i).
- duty 0: output constantly low.
- duty >= FULL+1: output constantly high.
- Coarse values above FULL are clamped to FULL+1 (always high).
- High cycles per metacycle = 2**DW*coarse + fine when coarse+1 <= FULL+1.

Sync
- pwm_s = 1 combinationally when cnt==FULL-1 and pcnt==2**DW-1, i.e. one cycle before the boundary.

Latency
- pwm_o reflects c_i with 1-cycle register delay.
- The first period using new shadow values starts the cycle after the boundary; the first output bit appears 1 cycle later still.

Decomposition:
- Package pwm_mc_pkg: localparam-derived widths, a function for the stagger offset, and typedef chan_cfg_t as a packed {coarse, fine} struct.
- Sub-module pwm_mc_chan, instantiated NCH times: holds shadow, accumulator, duty register and output compare.
- Counters and handshake live in the top level.

Test Plan:
1. Reset release, NCH=4, VW=8, DW=4, FULL=255; no upd_req -> pwm_o=0 indefinitely; pwm_s pulses every 4096 cycles, first at cycle 4094 after release.
2. upd_req pulse, ch0 cfg=0x804, en=1 -> upd_ack exactly 1 cycle after the first boundary; over the next 4096 cycles ch0 high for 128*16+4 = 2052 cycles; each period high 128 or 129 cycles.
3. ch1 coarse=0, fine=0 -> never high; ch2 coarse=255, fine=15 -> high every cycle of 15 periods, 255 cycles in 1; ch3 en=0 with cfg=0xFFF -> always low.
4. Stagger case: STAGGER=1, all channels cfg=0x400 -> rising edges of ch0..3 exactly 64 cycles apart.
5. Timing of upd_req: upd_req asserted on the boundary cycle with new cfg -> captured at that boundary. cfg changed mid-metacycle without upd_req -> no output change.
6. Async rst pulse mid-period while pending=1 -> pwm_o=0 at once; no upd_ack afterwards until a new upd_req is issued.
